// File: rtl/interrupt_controller.sv
// Eight-source interrupt controller: synchronized edge/level capture, fixed
// priority (bit 7 highest), and a non-preemptive request/ack/eoi handshake.
module interrupt_controller #(
    parameter logic [7:0] EDGE_SEL   = 8'hFF,
    parameter logic [7:0] ENABLE_RST = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] irq,
    input  logic       en_we,
    input  logic [7:0] en_wdata,
    input  logic       int_ack,
    input  logic       eoi,
    output logic       int_req,
    output logic [2:0] int_id,
    output logic       in_service,
    output logic [7:0] pending,
    output logic [7:0] enable
);

    typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_t;

    state_t     state_q, state_d;
    logic [7:0] sync1_q, sync2_q, sync3_q;
    logic [2:0] vld_pipe_q, vld_pipe_d;
    logic [7:0] pend_q, pend_d;
    logic [7:0] en_q, en_d;
    logic [2:0] id_q, id_d;

    logic [7:0] edge_det, masked, clr;
    logic [2:0] cand_id;
    logic       cand_vld, ack_take;

    always_comb begin
        // sync3 only carries a real sample once three edges have passed since
        // reset; this keeps an irq already high at release from looking like an edge.
        vld_pipe_d = {vld_pipe_q[1:0], 1'b1};
        edge_det   = sync2_q & ~sync3_q & {8{vld_pipe_q[2]}};
        masked     = pend_q & en_q;
        cand_id    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (masked[i]) cand_id = 3'(i);
        end
        cand_vld = |masked;
        ack_take = (state_q == REQUEST) && int_ack;
        clr      = ack_take ? (8'b1 << id_q) : 8'b0;
        // Edge sources: a fresh edge beats the ack clear. Level sources follow sync2.
        pend_d   = (EDGE_SEL & (edge_det | (pend_q & ~clr))) | (~EDGE_SEL & sync2_q);
        en_d     = en_we ? en_wdata : en_q;
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                if (cand_vld) begin
                    state_d = REQUEST;
                    id_d    = cand_id;
                end
            end
            REQUEST: begin
                if (int_ack)           state_d = SERVICE;
                else if (!masked[id_q]) state_d = IDLE;
            end
            SERVICE: begin
                if (eoi) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 8'h00;
            sync2_q    <= 8'h00;
            sync3_q    <= 8'h00;
            vld_pipe_q <= 3'b000;
            pend_q     <= 8'h00;
            en_q       <= ENABLE_RST;
            state_q    <= IDLE;
            id_q       <= 3'd0;
        end else begin
            sync1_q    <= irq;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            vld_pipe_q <= vld_pipe_d;
            pend_q     <= pend_d;
            en_q       <= en_d;
            state_q    <= state_d;
            id_q       <= id_d;
        end
    end

    assign int_req    = (state_q == REQUEST);
    assign in_service = (state_q == SERVICE);
    assign int_id     = id_q;
    assign pending    = pend_q;
    assign enable     = en_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed literal checks plus randomized
// traffic compared every cycle against a sample-history reference model.
module tb_interrupt_controller;

    localparam logic [7:0] ESEL = 8'hFD;  // bit 1 is a level source
    localparam logic [7:0] ERST = 8'h5A;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] irq = 8'h00;
    logic       en_we = 1'b0;
    logic [7:0] en_wdata = 8'h00;
    logic       int_ack = 1'b0;
    logic       eoi = 1'b0;
    logic       int_req, in_service;
    logic [2:0] int_id;
    logic [7:0] pending, enable;

    int n_cmp = 0;
    int n_err = 0;

    interrupt_controller #(.EDGE_SEL(ESEL), .ENABLE_RST(ERST)) dut (
        .clk(clk), .reset(reset), .irq(irq), .en_we(en_we), .en_wdata(en_wdata),
        .int_ack(int_ack), .eoi(eoi), .int_req(int_req), .int_id(int_id),
        .in_service(in_service), .pending(pending), .enable(enable)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: irq samples taken at each edge since reset release,
    // and the request/service status of the controller.
    logic [7:0] samp[$];
    logic [7:0] m_pend, m_en;
    bit         m_req, m_svc;
    int         m_id;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            samp.delete();
            m_pend = 8'h00;
            m_en   = ERST;
            m_req  = 0;
            m_svc  = 0;
            m_id   = 0;
        end else begin
            logic [7:0] synced, prev, rose, nxt, act;
            int n, cand;
            bit clr_hit;
            n      = samp.size();
            synced = (n >= 2) ? samp[n-2] : 8'h00;
            prev   = (n >= 3) ? samp[n-3] : 8'h00;
            rose   = (n >= 3) ? (synced & ~prev) : 8'h00;
            act    = m_pend & m_en;
            cand   = -1;
            for (int i = 7; i >= 0; i--) if (cand < 0 && act[i]) cand = i;
            for (int i = 0; i < 8; i++) begin
                clr_hit = m_req && int_ack && (m_id == i);
                if (ESEL[i]) nxt[i] = rose[i] ? 1'b1 : (clr_hit ? 1'b0 : m_pend[i]);
                else         nxt[i] = synced[i];
            end
            if (m_req) begin
                if (int_ack) begin m_req = 0; m_svc = 1; end
                else if (!act[m_id]) m_req = 0;
            end else if (m_svc) begin
                if (eoi) m_svc = 0;
            end else if (cand >= 0) begin
                m_req = 1;
                m_id  = cand;
            end
            m_pend = nxt;
            if (en_we) m_en = en_wdata;
            samp.push_back(irq);
            if (samp.size() > 3) void'(samp.pop_front());
        end
    end

    always @(negedge clk) begin
        check("int_req",    int_req,    m_req);
        check("in_service", in_service, m_svc);
        check("int_id",     int_id,     m_id);
        check("pending",    pending,    m_pend);
        check("enable",     enable,     m_en);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        repeat (4) tick();  // irq held steady while the synchronizers refill
    endtask

    initial begin
        tick(); tick();
        check("rst_int_req", int_req, 0);
        check("rst_in_service", in_service, 0);
        check("rst_pending", pending, 8'h00);
        check("rst_enable", enable, 8'h5A);
        check("rst_int_id", int_id, 0);
        reset = 1'b1;
        repeat (4) tick();

        // Edge source 3: four-edge latency, ack clears, eoi returns to idle.
        en_we = 1; en_wdata = 8'hFF; tick(); en_we = 0;
        check("en_write", enable, 8'hFF);
        irq[3] = 1; tick(); tick(); tick(); irq[3] = 0;
        check("lat_edge3_low", int_req, 0);
        tick();
        check("lat_edge4_req", int_req, 1);
        check("lat_id3", int_id, 3);
        int_ack = 1; tick(); int_ack = 0;
        check("ack_svc", in_service, 1);
        check("ack_clr3", pending[3], 0);
        eoi = 1; tick(); eoi = 0;
        check("eoi_idle", in_service, 0);
        tick();
        check("eoi_noreq", int_req, 0);

        // Edge source 4: a new edge on the ack edge keeps the bit pending.
        irq[4] = 1; repeat (4) tick();
        check("req_id4", int_id, 4);
        irq[4] = 0; repeat (3) tick();
        irq[4] = 1; tick(); tick();
        int_ack = 1; tick(); int_ack = 0;
        check("set_wins_svc", in_service, 1);
        check("set_wins_pend4", pending[4], 1);
        eoi = 1; tick(); eoi = 0; tick();
        check("rereq4", int_req, 1);
        check("rereq_id4", int_id, 4);
        int_ack = 1; tick(); int_ack = 0;
        irq[4] = 0;

        // Asynchronous reset in SERVICE, observed before the next clock edge.
        #1 reset = 1'b0;
        #1;
        check("arst_in_service", in_service, 0);
        check("arst_int_req", int_req, 0);
        check("arst_pending", pending, 8'h00);
        check("arst_enable", enable, 8'h5A);
        tick(); reset = 1'b1;
        repeat (4) tick();

        // Masked edge on 5 stays pending; enabling it requests one edge later.
        en_we = 1; en_wdata = 8'h00; tick(); en_we = 0;
        irq[5] = 1; repeat (3) tick(); irq[5] = 0; repeat (2) tick();
        check("mask_pend5", pending[5], 1);
        check("mask_noreq", int_req, 0);
        en_we = 1; en_wdata = 8'h20; tick(); en_we = 0;
        check("en_w_noreq", int_req, 0);
        tick();
        check("en_req", int_req, 1);
        check("en_id5", int_id, 5);
        int_ack = 1; tick(); int_ack = 0;
        eoi = 1; tick(); eoi = 0;

        // Randomized traffic checked each cycle by the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 5) == 0) irq[$urandom_range(0, 7)] ^= 1'b1;
                en_we    = ($urandom_range(0, 31) == 0);
                en_wdata = 8'($urandom | $urandom);
                int_ack  = (m_req && $urandom_range(0, 2) == 0) || ($urandom_range(0, 15) == 0);
                eoi      = (m_svc && $urandom_range(0, 3) == 0) || ($urandom_range(0, 15) == 0);
                tick();
            end
        end
        en_we = 0; int_ack = 0; eoi = 0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
